// File: rtl/sim_run_ctrl.sv
// ---------------------------------------------------------------------------
// sim_run_ctrl
//   Run controller for CPU simulation benches. Sequences the core reset,
//   counts run cycles, watches the core pc and ends the run on pc self-loop
//   (halt), misaligned pc (error) or exhausted cycle budget (timeout). The
//   verdict is sticky until the next master reset.
//
// Ports
//   i_clk        in   1      single clock, all state updates on posedge
//   i_rst        in   1      synchronous active-high master reset
//   i_pc         in   PC_W   core pc, sampled every cycle in RUN
//   o_cpu_rst    out  1      core reset, active-high
//   o_running    out  1      high while in RUN
//   o_done       out  1      sticky, run finished
//   o_halted     out  1      sticky, pc self-loop detected
//   o_timeout    out  1      sticky, cycle budget exhausted
//   o_pc_err     out  1      sticky, misaligned pc observed
//   o_cycle_cnt  out  CNT_W  RUN cycles elapsed, frozen in DONE
//   o_last_pc    out  PC_W   last pc sampled in RUN, frozen in DONE
// ---------------------------------------------------------------------------
module sim_run_ctrl #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned MAX_CYCLES  = 100000,
  parameter int unsigned HALT_REPEAT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PC_W-1:0]  i_pc,
  output logic             o_cpu_rst,
  output logic             o_running,
  output logic             o_done,
  output logic             o_halted,
  output logic             o_timeout,
  output logic             o_pc_err,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [PC_W-1:0]  o_last_pc
);

  // Counters only need to reach their terminal value minus one.
  localparam int unsigned RST_W  = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
  localparam int unsigned SAME_W = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [RST_W-1:0]  r_rst_cnt;
  logic [SAME_W-1:0] r_same_cnt;
  logic              r_pc_vld;
  logic              r_cpu_rst;
  logic              r_running;
  logic              r_done;
  logic              r_halted;
  logic              r_timeout;
  logic              r_pc_err;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [PC_W-1:0]   r_last_pc;

  logic [RST_W-1:0]  w_rst_cnt_nxt;
  logic [SAME_W-1:0] w_same_cnt_nxt;
  logic              w_pc_vld_nxt;
  logic              w_cpu_rst_nxt;
  logic              w_running_nxt;
  logic              w_done_nxt;
  logic              w_halted_nxt;
  logic              w_timeout_nxt;
  logic              w_pc_err_nxt;
  logic [CNT_W-1:0]  w_cycle_cnt_nxt;
  logic [PC_W-1:0]   w_last_pc_nxt;

  // Terminal conditions evaluated on the incoming pc sample.
  logic w_rst_last;
  logic w_repeat;
  logic w_misalign;
  logic w_halt_hit;
  logic w_budget_hit;
  logic w_end_run;

  assign w_rst_last   = (r_rst_cnt == RST_W'(RST_CYCLES - 1));
  // The very first RUN sample has no predecessor, so it never counts as a repeat.
  assign w_repeat     = r_pc_vld && (i_pc == r_last_pc);
  assign w_misalign   = |i_pc[1:0];
  assign w_halt_hit   = w_repeat && (r_same_cnt == SAME_W'(HALT_REPEAT - 1));
  assign w_budget_hit = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_end_run    = w_misalign || w_halt_hit || w_budget_hit;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET: if (w_rst_last) w_state_nxt = S_RUN;
      S_RUN:   if (w_end_run)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Output/datapath next values; everything holds unless the state says otherwise.
  always_comb begin
    w_rst_cnt_nxt   = r_rst_cnt;
    w_same_cnt_nxt  = r_same_cnt;
    w_pc_vld_nxt    = r_pc_vld;
    w_cpu_rst_nxt   = r_cpu_rst;
    w_running_nxt   = r_running;
    w_done_nxt      = r_done;
    w_halted_nxt    = r_halted;
    w_timeout_nxt   = r_timeout;
    w_pc_err_nxt    = r_pc_err;
    w_cycle_cnt_nxt = r_cycle_cnt;
    w_last_pc_nxt   = r_last_pc;

    case (r_state)
      S_RESET: begin
        w_cpu_rst_nxt = 1'b1;
        if (w_rst_last) begin
          w_cpu_rst_nxt = 1'b0;
          w_running_nxt = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
        end
      end

      S_RUN: begin
        w_last_pc_nxt   = i_pc;
        w_pc_vld_nxt    = 1'b1;
        w_cycle_cnt_nxt = r_cycle_cnt + CNT_W'(1);
        w_same_cnt_nxt  = w_repeat ? (r_same_cnt + SAME_W'(1)) : '0;
        // Only one verdict flag is raised: misalign beats halt beats timeout.
        if (w_end_run) begin
          w_done_nxt    = 1'b1;
          w_running_nxt = 1'b0;
          if (w_misalign) begin
            w_pc_err_nxt = 1'b1;
          end else if (w_halt_hit) begin
            w_halted_nxt = 1'b1;
          end else begin
            w_timeout_nxt = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Core keeps running out of reset so the bench can observe it.
        w_cpu_rst_nxt = 1'b0;
        w_running_nxt = 1'b0;
      end

      default: begin
        w_cpu_rst_nxt = 1'b1;
        w_running_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and run bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rst_cnt   <= '0;
      r_same_cnt  <= '0;
      r_pc_vld    <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
      r_pc_err    <= 1'b0;
      r_cycle_cnt <= '0;
      r_last_pc   <= '0;
    end else begin
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_same_cnt  <= w_same_cnt_nxt;
      r_pc_vld    <= w_pc_vld_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_running   <= w_running_nxt;
      r_done      <= w_done_nxt;
      r_halted    <= w_halted_nxt;
      r_timeout   <= w_timeout_nxt;
      r_pc_err    <= w_pc_err_nxt;
      r_cycle_cnt <= w_cycle_cnt_nxt;
      r_last_pc   <= w_last_pc_nxt;
    end
  end

  assign o_cpu_rst   = r_cpu_rst;
  assign o_running   = r_running;
  assign o_done      = r_done;
  assign o_halted    = r_halted;
  assign o_timeout   = r_timeout;
  assign o_pc_err    = r_pc_err;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_last_pc   = r_last_pc;

endmodule
